// File: rtl/sprite_plotter.sv
// sprite_plotter: copies one ROM sprite into the frame buffer,
// one pixel per clock, with colour-key and screen-edge clipping.
module sprite_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ADDR_W = 15,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          obj_x,
  input  logic [6:0]          obj_y,
  input  logic [7:0]          obj_w,
  input  logic [6:0]          obj_h,
  input  logic [ADDR_W-1:0]   rom_base,
  input  logic                key_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                plot_done
);

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t nextState;

  logic [7:0]          xReg;
  logic [6:0]          yReg;
  logic [7:0]          wReg;
  logic [6:0]          hReg;
  logic                keyReg;

  logic [7:0]          colCnt;
  logic [6:0]          rowCnt;
  logic [ADDR_W-1:0]   addrCnt;

  logic                pipeValid;
  logic [8:0]          pipeX;
  logic [7:0]          pipeY;

  logic [7:0]          lastX;
  logic [6:0]          lastY;
  logic [COLOUR_W-1:0] lastColour;

  logic zeroSize;
  logic accept;
  logic issue;
  logic lastCol;
  logic lastPix;
  logic clipped;
  logic keyed;
  logic plotNow;

  assign zeroSize = (obj_w == 8'd0)
                 || (obj_h == 7'd0);
  assign lastCol  = colCnt == wReg - 8'd1;
  assign lastPix  = lastCol
                 && (rowCnt == hReg - 7'd1);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // next-state decode and per-cycle strobes
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = zeroSize ? DONE : RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (lastPix) begin
          nextState = DRAIN;
        end
      end
      DRAIN: nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // descriptor latch, only on the accepting cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xReg   <= '0;
      yReg   <= '0;
      wReg   <= '0;
      hReg   <= '0;
      keyReg <= 1'b0;
    end else if (accept) begin
      xReg   <= obj_x;
      yReg   <= obj_y;
      wReg   <= obj_w;
      hReg   <= obj_h;
      keyReg <= key_en;
    end
  end

  // column/row/address walk; empty sprites leave the address alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colCnt  <= '0;
      rowCnt  <= '0;
      addrCnt <= '0;
    end else if (accept) begin
      colCnt <= '0;
      rowCnt <= '0;
      if (!zeroSize) begin
        addrCnt <= rom_base;
      end
    end else if (issue) begin
      addrCnt <= addrCnt + ADDR_W'(1);
      if (lastCol) begin
        colCnt <= '0;
        rowCnt <= rowCnt + 7'd1;
      end else begin
        colCnt <= colCnt + 8'd1;
      end
    end
  end

  // stage 1: screen position aligned with the ROM read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipeValid <= 1'b0;
      pipeX     <= '0;
      pipeY     <= '0;
    end else begin
      pipeValid <= issue;
      if (issue) begin
        pipeX <= {1'b0, xReg} + {1'b0, colCnt};
        pipeY <= {1'b0, yReg} + {1'b0, rowCnt};
      end
    end
  end

  assign clipped = (pipeX >= X_LIM)
                || (pipeY >= Y_LIM);
  assign keyed   = keyReg
                && (rom_q == KEY_COLOUR);
  assign plotNow = pipeValid
                && !clipped
                && !keyed;

  // hold the last written pixel so the write bus stays stable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastX      <= '0;
      lastY      <= '0;
      lastColour <= '0;
    end else if (plotNow) begin
      lastX      <= pipeX[7:0];
      lastY      <= pipeY[6:0];
      lastColour <= rom_q;
    end
  end

  assign vga_plot   = plotNow;
  assign vga_x      = plotNow ? pipeX[7:0] : lastX;
  assign vga_y      = plotNow ? pipeY[6:0] : lastY;
  assign vga_colour = plotNow ? rom_q : lastColour;
  assign rom_addr   = addrCnt;
  assign busy       = state != IDLE;
  assign plot_done  = state == DONE;

endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: scoreboard bench with a pixel-list
// reference model of the sprite copy.
module tb_sprite_plotter;

  localparam int AW = 15;
  localparam int ROMN = 32768;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    obj_x = '0;
  logic [6:0]    obj_y = '0;
  logic [7:0]    obj_w = '0;
  logic [6:0]    obj_h = '0;
  logic [AW-1:0] rom_base = '0;
  logic          key_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [2:0]    rom_q;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;
  logic          busy;
  logic          plot_done;

  logic [2:0] romMem [0:ROMN-1];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  pix_t plotQ[$];
  int   doneQ[$];
  pix_t mon;
  int   monT;
  bit   hadPlot = 1'b0;
  int   lastX = 0;
  int   lastY = 0;
  int   lastC = 0;

  sprite_plotter dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .obj_x(obj_x),
    .obj_y(obj_y),
    .obj_w(obj_w),
    .obj_h(obj_h),
    .rom_base(rom_base),
    .key_en(key_en),
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_colour(vga_colour),
    .vga_plot(vga_plot),
    .busy(busy),
    .plot_done(plot_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_q <= romMem[rom_addr];

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // reference: every pixel of the rectangle, in raster order
  task automatic model(input int x, input int y,
                       input int w, input int h,
                       input int base, input int key,
                       input int t0);
    pix_t p;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int i;
        int col;
        i   = r * w + c;
        col = int'(romMem[(base + i) % ROMN]);
        if (x + c < 160 && y + r < 120
            && !(key != 0 && col == 0)) begin
          p.x = x + c;
          p.y = y + r;
          p.c = col;
          p.t = t0 + 1 + i;
          plotQ.push_back(p);
        end
      end
    end
    if (w == 0 || h == 0) doneQ.push_back(t0);
    else doneQ.push_back(t0 + w * h + 1);
  endtask

  task automatic startCopy(input int x, input int y,
                           input int w, input int h,
                           input int base, input int key,
                           input bit keep, output int t0);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 600);
    chk(!busy, "idle_wait", int'(busy), 0);
    obj_x    = 8'(x);
    obj_y    = 7'(y);
    obj_w    = 8'(w);
    obj_h    = 7'(h);
    rom_base = AW'(base);
    key_en   = key[0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    model(x, y, w, h, base, key, t0);
    if (!keep) start = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!plot_done && n < 600);
    chk(plot_done, "done_wait", int'(plot_done), 1);
  endtask

  // monitor: every plot / done pulse is matched against the queues
  always @(negedge clk) begin
    if (reset) begin
      if (vga_plot) begin
        if (plotQ.size() == 0) begin
          chk(1'b0 == vga_plot, "unexpected_plot",
              int'(vga_x), -1);
        end else begin
          mon = plotQ.pop_front();
          chk(vga_x == mon.x, "plot_x", int'(vga_x), mon.x);
          chk(vga_y == mon.y, "plot_y", int'(vga_y), mon.y);
          chk(vga_colour == mon.c, "plot_colour",
              int'(vga_colour), mon.c);
          chk(cyc == mon.t, "plot_cycle", cyc, mon.t);
          lastX = mon.x;
          lastY = mon.y;
          lastC = mon.c;
        end
      end else if (hadPlot) begin
        chk(vga_x == lastX, "hold_x", int'(vga_x), lastX);
        chk(vga_y == lastY, "hold_y", int'(vga_y), lastY);
        chk(vga_colour == lastC, "hold_colour",
            int'(vga_colour), lastC);
      end
      if (plot_done) begin
        if (doneQ.size() == 0) begin
          chk(1'b0 == plot_done, "unexpected_done", cyc, -1);
        end else begin
          monT = doneQ.pop_front();
          chk(cyc == monT, "done_cycle", cyc, monT);
        end
      end
    end
  end

  initial begin
    int t0;
    int a0;
    int d0;
    for (int i = 0; i < ROMN; i++) romMem[i] = 3'($urandom);
    hadPlot = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk(vga_plot == 0, "rst_plot", int'(vga_plot), 0);
    chk(busy == 0, "rst_busy", int'(busy), 0);
    chk(plot_done == 0, "rst_done", int'(plot_done), 0);
    chk(rom_addr == 0, "rst_addr", int'(rom_addr), 0);
    chk(vga_x == 0, "rst_x", int'(vga_x), 0);
    @(negedge clk);
    reset = 1'b1;

    romMem[100] = 3'd1;
    romMem[101] = 3'd2;
    romMem[102] = 3'd3;
    romMem[103] = 3'd4;
    startCopy(10, 20, 2, 2, 100, 0, 1'b0, t0);
    chk(busy == 1, "busy_run", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      chk(rom_addr == 100 + i, "rom_addr",
          int'(rom_addr), 100 + i);
      @(posedge clk);
      #1;
    end
    waitDone();

    romMem[101] = 3'd0;
    startCopy(10, 20, 2, 2, 100, 1, 1'b0, t0);
    waitDone();

    startCopy(158, 119, 4, 2, 200, 0, 1'b0, t0);
    waitDone();

    a0 = int'(rom_addr);
    startCopy(30, 30, 0, 5, 500, 0, 1'b0, t0);
    waitDone();
    chk(rom_addr == a0, "zero_addr", int'(rom_addr), a0);

    startCopy(0, 0, 1, 1, 300, 0, 1'b1, t0);
    waitDone();
    d0 = cyc;
    startCopy(5, 5, 1, 1, 301, 0, 1'b0, t0);
    chk(t0 == d0 + 2, "rearm_edge", t0, d0 + 2);
    waitDone();

    for (int k = 0; k < 40; k++) begin
      int x;
      int y;
      int w;
      int h;
      int b;
      int key;
      bit keep;
      x = int'($urandom_range(0, 175));
      y = int'($urandom_range(0, 127));
      w = ($urandom_range(0, 7) == 0) ? 0
          : int'($urandom_range(1, 12));
      h = ($urandom_range(0, 7) == 0) ? 0
          : int'($urandom_range(1, 9));
      b = ($urandom_range(0, 3) == 0)
          ? ROMN - int'($urandom_range(1, 40))
          : int'($urandom_range(0, ROMN - 1));
      key  = int'($urandom_range(0, 1));
      keep = (k < 39) && ($urandom_range(0, 3) == 0);
      startCopy(x, y, w, h, b, key, keep, t0);
      waitDone();
    end

    startCopy(20, 30, 8, 8, 1000, 0, 1'b0, t0);
    repeat (20) @(posedge clk);
    #2;
    chk(busy == 1, "busy_mid", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk(vga_plot == 0, "abort_plot", int'(vga_plot), 0);
    chk(busy == 0, "abort_busy", int'(busy), 0);
    chk(plot_done == 0, "abort_done", int'(plot_done), 0);
    plotQ.delete();
    doneQ.delete();
    lastX = 0;
    lastY = 0;
    lastC = 0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    startCopy(40, 40, 1, 1, 2000, 0, 1'b0, t0);
    waitDone();
    chk(cyc == t0 + 2, "post_reset_done", cyc, t0 + 2);

    repeat (3) @(negedge clk);
    chk(plotQ.size() == 0, "plots_left", plotQ.size(), 0);
    chk(doneQ.size() == 0, "dones_left", doneQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
